efpga_config_write_scheduler: RTL and testbench



---
 rtl/efpga_cfg_pkg.sv | 19 +
 rtl/efpga_config_write_scheduler_if.sv | 38 +++
 rtl/efpga_cfg_fifo.sv | 51 +++++
 rtl/efpga_config_write_scheduler.sv | 153 +++++++++++++++
 tb/tb_efpga_config_write_scheduler.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/efpga_cfg_pkg.sv
// Shared types and constants for the eFPGA configuration write scheduler.
package efpga_cfg_pkg;

  // Width of one configuration word on the self-write port.
  localparam int unsigned CFG_WORD_W = 32;

  // Default pacing gap and word buffer depth.
  localparam int unsigned DEFAULT_STROBE_GAP = 2;
  localparam int unsigned DEFAULT_FIFO_DEPTH = 4;

  // Frame sequencing states.
  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StGap,
    StDone
  } cfg_state_e;

endpackage

// File: rtl/efpga_config_write_scheduler_if.sv
// Bundle of the scheduler's control, requester and self-write signals.
interface efpga_config_write_scheduler_if #(
  parameter int unsigned CNT_W = 16
);
  import efpga_cfg_pkg::*;

  logic                  start;
  logic                  abort;
  logic [CNT_W-1:0]      expected_words;
  logic                  req0_valid;
  logic [CFG_WORD_W-1:0] req0_data;
  logic                  req0_ready;
  logic                  req1_valid;
  logic [CFG_WORD_W-1:0] req1_data;
  logic                  req1_ready;
  logic                  SelfWriteStrobe;
  logic [CFG_WORD_W-1:0] SelfWriteData;
  logic [CNT_W-1:0]      word_count;
  logic                  busy;
  logic                  done;

  // Driver side: control and requesters.
  modport master (
    output start, abort, expected_words,
    output req0_valid, req0_data, req1_valid, req1_data,
    input  req0_ready, req1_ready,
    input  SelfWriteStrobe, SelfWriteData, word_count, busy, done
  );

  // Scheduler side.
  modport slave (
    input  start, abort, expected_words,
    input  req0_valid, req0_data, req1_valid, req1_data,
    output req0_ready, req1_ready,
    output SelfWriteStrobe, SelfWriteData, word_count, busy, done
  );

endinterface

// File: rtl/efpga_cfg_fifo.sv
// Synchronous word FIFO with flush; pointers carry an extra wrap bit so
// full and empty are distinguishable without a separate count.
module efpga_cfg_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             resetn_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AddrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW:0]   wr_ptr_q;
  logic [AddrW:0]   rd_ptr_q;
  logic             push_en;
  logic             pop_en;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                   (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
  assign push_en = push_i && !full_o;
  assign pop_en  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q[AddrW-1:0]];

  // Storage array; contents need no reset, validity is tracked by the pointers.
  always_ff @(posedge clk_i) begin
    if (push_en) begin
      mem_q[wr_ptr_q[AddrW-1:0]] <= data_i;
    end
  end

  // Read/write pointers with synchronous reset and flush.
  always_ff @(posedge clk_i) begin
    if (!resetn_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_en)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

endmodule

// File: rtl/efpga_config_write_scheduler.sv
// Arbitrates two config word sources into a FIFO and paces them onto the
// eFPGA self-write port, counting words against a programmed frame length.
module efpga_config_write_scheduler
  import efpga_cfg_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
  parameter int unsigned STROBE_GAP = DEFAULT_STROBE_GAP,
  parameter int unsigned CNT_W      = 16
) (
  input logic                           CLK,
  input logic                           resetn,
  efpga_config_write_scheduler_if.slave bus
);

  // Gap counter holds STROBE_GAP-1 down to 0; keep at least one bit.
  localparam int unsigned GapW    = (STROBE_GAP > 1) ? $clog2(STROBE_GAP) : 1;
  localparam int unsigned GapLoad = (STROBE_GAP > 0) ? STROBE_GAP - 1 : 0;
  localparam logic [GapW-1:0] GapLoadV = GapW'(GapLoad);

  cfg_state_e            state_q, state_d;
  logic [CNT_W-1:0]      len_q, len_d;
  logic [CNT_W-1:0]      acc_q, acc_d;
  logic [CNT_W-1:0]      iss_q, iss_d;
  logic [GapW-1:0]       gap_q, gap_d;
  logic                  rr_q, rr_d;       // 1: requester 1 wins a tie
  logic                  strobe_q, strobe_d;
  logic [CFG_WORD_W-1:0] data_q, data_d;

  logic                  can_accept;
  logic                  grant0;
  logic                  grant1;
  logic                  push;
  logic [CFG_WORD_W-1:0] push_data;
  logic                  issue;
  logic                  last_word;
  logic [CFG_WORD_W-1:0] fifo_head;
  logic                  fifo_full;
  logic                  fifo_empty;

  // Accept gate and round-robin grant; at most one requester per cycle.
  always_comb begin
    can_accept = resetn && ((state_q == StRun) || (state_q == StGap)) && !fifo_full &&
                 (acc_q < len_q) && !bus.abort;
    grant0     = can_accept && bus.req0_valid && (!bus.req1_valid || !rr_q);
    grant1     = can_accept && bus.req1_valid && (!bus.req0_valid || rr_q);
    push       = grant0 || grant1;
    push_data  = grant1 ? bus.req1_data : bus.req0_data;
    issue      = (state_q == StRun) && !fifo_empty && !bus.abort;
  end

  efpga_cfg_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (CFG_WORD_W)
  ) u_fifo (
    .clk_i    (CLK),
    .resetn_i (resetn),
    .flush_i  (bus.abort),
    .push_i   (push),
    .data_i   (push_data),
    .pop_i    (issue),
    .data_o   (fifo_head),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty)
  );

  // Next-state logic for the frame FSM, counters and the write port.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    acc_d     = acc_q + CNT_W'(push);
    iss_d     = iss_q;
    gap_d     = gap_q;
    rr_d      = rr_q;
    strobe_d  = 1'b0;
    data_d    = data_q;
    last_word = ((iss_q + CNT_W'(1)) == len_q);

    if (grant0) rr_d = 1'b1;
    if (grant1) rr_d = 1'b0;

    if (bus.abort) begin
      // Abort beats start, accept and issue; word_count is left visible.
      state_d = StIdle;
      gap_d   = '0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (bus.start) begin
            len_d   = bus.expected_words;
            acc_d   = '0;
            iss_d   = '0;
            gap_d   = '0;
            state_d = (bus.expected_words == '0) ? StDone : StRun;
          end
        end
        StRun: begin
          if (issue) begin
            strobe_d = 1'b1;
            data_d   = fifo_head;
            iss_d    = iss_q + CNT_W'(1);
            gap_d    = GapLoadV;
            // The final word ends the frame immediately, without a trailing gap.
            if (last_word) begin
              state_d = StDone;
            end else if (STROBE_GAP != 0) begin
              state_d = StGap;
            end
          end
        end
        StGap: begin
          if (gap_q == '0) begin
            state_d = StRun;
          end else begin
            gap_d = gap_q - 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!resetn) begin
      state_q  <= StIdle;
      len_q    <= '0;
      acc_q    <= '0;
      iss_q    <= '0;
      gap_q    <= '0;
      rr_q     <= 1'b0;
      strobe_q <= 1'b0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      acc_q    <= acc_d;
      iss_q    <= iss_d;
      gap_q    <= gap_d;
      rr_q     <= rr_d;
      strobe_q <= strobe_d;
      data_q   <= data_d;
    end
  end

  assign bus.req0_ready      = grant0;
  assign bus.req1_ready      = grant1;
  assign bus.SelfWriteStrobe = strobe_q;
  assign bus.SelfWriteData   = data_q;
  assign bus.word_count      = iss_q;
  assign bus.busy            = (state_q == StRun) || (state_q == StGap);
  assign bus.done            = (state_q == StDone);

endmodule

// File: tb/tb_efpga_config_write_scheduler.sv
// Self-checking bench: directed scenarios plus random frames, all compared
// against a queue-based reference model of the scheduler's rules.
module tb_efpga_config_write_scheduler;

  localparam int unsigned GAP   = 2;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = 16;
  localparam int PIdle   = 0;
  localparam int PActive = 1;
  localparam int PDone   = 2;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  efpga_config_write_scheduler_if #(.CNT_W(CW)) bus ();

  efpga_config_write_scheduler #(
    .FIFO_DEPTH (DEPTH),
    .STROBE_GAP (GAP),
    .CNT_W      (CW)
  ) dut (
    .CLK    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model
  int          m_phase;
  logic [31:0] m_q[$];
  int          m_len, m_acc, m_iss, m_wait, m_last;
  bit          m_strobe;
  logic [31:0] m_data;

  // Word sources: each requester offers base+count, count advancing on accept.
  logic [31:0] r0_base, r1_base;
  int          r0_cnt, r1_cnt;

  // Observations from the most recent step.
  bit          obs_strobe, obs_g0, obs_g1;
  logic [31:0] obs_data;
  int          cyc = 0;

  int          n_str, n_rdy, stall;
  int          st_cyc[16];
  logic [31:0] st_dat[16];
  logic [31:0] next_word;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase  = PIdle;
    m_q.delete();
    m_len    = 0;
    m_acc    = 0;
    m_iss    = 0;
    m_wait   = 0;
    m_last   = 1;
    m_strobe = 1'b0;
    m_data   = '0;
  endtask

  // One clock: drive inputs, check readies, advance the model, check outputs.
  task automatic step(input bit rstn, input bit v0, input bit v1, input bit st, input bit ab,
                      input int ew);
    bit can, g0, g1;
    logic [31:0] w0, w1;
    w0 = r0_base + r0_cnt;
    w1 = r1_base + r1_cnt;
    resetn             = rstn;
    bus.req0_valid     = v0;
    bus.req0_data      = w0;
    bus.req1_valid     = v1;
    bus.req1_data      = w1;
    bus.start          = st;
    bus.abort          = ab;
    bus.expected_words = ew[CW-1:0];
    #1;
    can = rstn && (m_phase == PActive) && (m_q.size() < DEPTH) && (m_acc < m_len) && !ab;
    g0 = 1'b0;
    g1 = 1'b0;
    if (can) begin
      if (v0 && v1) begin
        if (m_last == 0) g1 = 1'b1;
        else             g0 = 1'b1;
      end else if (v0) g0 = 1'b1;
      else if (v1)     g1 = 1'b1;
    end
    if (rstn) begin
      chk("req0_ready", {31'b0, bus.req0_ready}, {31'b0, g0});
      chk("req1_ready", {31'b0, bus.req1_ready}, {31'b0, g1});
    end
    obs_g0 = bus.req0_ready;
    obs_g1 = bus.req1_ready;
    @(posedge clk);
    if (!rstn) begin
      model_reset();
    end else if (ab) begin
      m_phase  = PIdle;
      m_q.delete();
      m_wait   = 0;
      m_strobe = 1'b0;
    end else if (m_phase != PActive) begin
      m_strobe = 1'b0;
      if (st) begin
        m_len   = ew;
        m_acc   = 0;
        m_iss   = 0;
        m_wait  = 0;
        m_phase = (ew == 0) ? PDone : PActive;
      end
    end else begin
      if (m_wait == 0 && m_q.size() > 0) begin
        m_data   = m_q.pop_front();
        m_strobe = 1'b1;
        m_iss++;
        m_wait   = GAP;
        if (m_iss == m_len) m_phase = PDone;
      end else begin
        m_strobe = 1'b0;
        if (m_wait > 0) m_wait--;
      end
      if (g0) begin m_q.push_back(w0); m_acc++; m_last = 0; r0_cnt++; end
      if (g1) begin m_q.push_back(w1); m_acc++; m_last = 1; r1_cnt++; end
    end
    @(negedge clk);
    cyc++;
    chk("strobe", {31'b0, bus.SelfWriteStrobe}, {31'b0, m_strobe});
    chk("data", bus.SelfWriteData, m_data);
    chk("word_count", {16'b0, bus.word_count}, m_iss);
    chk("busy", {31'b0, bus.busy}, {31'b0, (m_phase == PActive)});
    chk("done", {31'b0, bus.done}, {31'b0, (m_phase == PDone)});
    obs_strobe = bus.SelfWriteStrobe;
    obs_data   = bus.SelfWriteData;
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
  endtask

  task automatic clr_log();
    n_str = 0;
    n_rdy = 0;
    stall = 0;
  endtask

  task automatic log_step();
    if (obs_g0 || obs_g1) n_rdy++;
    if (obs_strobe && n_str < 16) begin
      st_cyc[n_str] = cyc;
      st_dat[n_str] = obs_data;
      n_str++;
    end
  endtask

  initial begin
    model_reset();
    r0_base = 32'h0;
    r1_base = 32'h0;
    r0_cnt  = 0;
    r1_cnt  = 0;

    // Reset state
    do_reset();
    chk("rst_data", bus.SelfWriteData, 32'h0);
    chk("rst_wc", {16'b0, bus.word_count}, 32'd0);

    // Single source, len=3
    r0_base = 32'hA000_0001;
    r0_cnt  = 0;
    clr_log();
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3);
    for (int i = 0; i < 14; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3);
      log_step();
    end
    chk("s1_nstrobe", n_str, 3);
    chk("s1_accepts", n_rdy, 3);
    chk("s1_space01", st_cyc[1] - st_cyc[0], 1 + GAP);
    chk("s1_space12", st_cyc[2] - st_cyc[1], 1 + GAP);
    chk("s1_word3", st_dat[2], 32'hA000_0003);
    chk("s1_wc", {16'b0, bus.word_count}, 32'd3);
    chk("s1_done", {31'b0, bus.done}, 32'd1);

    // Contention, len=4
    do_reset();
    r0_base = 32'h0000_0100; r0_cnt = 0;
    r1_base = 32'h1000_0200; r1_cnt = 0;
    clr_log();
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4);
      log_step();
    end
    chk("s2_nstrobe", n_str, 4);
    for (int i = 0; i < 4; i++) begin
      chk("s2_order", {28'b0, st_dat[i][31:28]}, i % 2);
    end

    // Backpressure, len=8: FIFO fills, readies drop, nothing lost
    do_reset();
    r0_base = 32'h2000_0000; r0_cnt = 0;
    r1_base = 32'h3000_0000; r1_cnt = 0;
    clr_log();
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8);
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8);
      if (bus.busy && !obs_g0 && !obs_g1 && n_rdy < 8) stall++;
      log_step();
    end
    chk("s3_nstrobe", n_str, 8);
    chk("s3_stalled", {31'b0, (stall > 0)}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      next_word = ((i % 2) == 0) ? (r0_base + i / 2) : (r1_base + i / 2);
      chk("s3_word", st_dat[i], next_word);
    end

    // Zero length
    do_reset();
    clr_log();
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 0);
    chk("s4_done", {31'b0, bus.done}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0);
      log_step();
    end
    chk("s4_nstrobe", n_str, 0);
    chk("s4_nready", n_rdy, 0);

    // Abort mid-frame after 2 strobes, then a fresh len=1 frame
    do_reset();
    r0_base = 32'hC000_0000; r0_cnt = 0;
    clr_log();
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 6);
    for (int i = 0; i < 30 && n_str < 2; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6);
      log_step();
    end
    chk("s5_reach2", n_str, 2);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 6);
    chk("s5_busy", {31'b0, bus.busy}, 32'd0);
    clr_log();
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6);
      log_step();
    end
    chk("s5_quiet", n_str, 0);
    next_word = r0_base + r0_cnt;
    clr_log();
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1);
      log_step();
    end
    chk("s5_nstrobe", n_str, 1);
    chk("s5_word", st_dat[0], next_word);

    // Random frames with stray starts and occasional aborts
    do_reset();
    for (int f = 0; f < 8; f++) begin
      int len;
      len     = $urandom_range(1, 9);
      r0_base = $urandom & 32'hFFFF_0000; r0_cnt = 0;
      r1_base = $urandom & 32'hFFFF_0000; r1_cnt = 0;
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, len);
      for (int i = 0; i < 40; i++) begin
        step(1'b1, ($urandom % 4) != 0, ($urandom % 4) != 0, ($urandom % 16) == 0,
             ($urandom % 60) == 0, $urandom_range(0, 9));
      end
    end

    // Reset while in the gap after a strobe
    do_reset();
    r0_base = 32'hE000_0000; r0_cnt = 0;
    clr_log();
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5);
    for (int i = 0; i < 10 && n_str < 1; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5);
      log_step();
    end
    chk("s6_strobe_seen", n_str, 1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5);
    chk("s6_rst_wc", {16'b0, bus.word_count}, 32'd0);
    chk("s6_rst_data", bus.SelfWriteData, 32'h0);
    clr_log();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5);
      log_step();
    end
    chk("s6_nstrobe", n_str, 0);
    chk("s6_nready", n_rdy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
